// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one floating-point adder between NREQ issue ports.
// Optional statistics counters (ops_done, stall_cycles) with FP_ADD_SCHED_STATS_EN.
module fp_add_sched #(
    parameter int NREQ    = 2,
    parameter int ADD_LAT = 1,
    parameter int IDW     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*141-1:0] req_op,
    output logic [140:0]        add_op,
    input  logic [10:0]         add_es,
    input  logic [56:0]         add_fs,
    input  logic                add_ss,
    input  logic [1:0]          add_fls,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [10:0]         rsp_es,
    output logic [56:0]         rsp_fs,
    output logic                rsp_ss,
    output logic [1:0]          rsp_fls,
    output logic                busy
`ifdef FP_ADD_SCHED_STATS_EN
    ,
    output logic [31:0]         ops_done,
    output logic [31:0]         stall_cycles
`endif
);
    localparam int OPW = 141;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, id_q, win, rr_nxt;
    logic [2:0]     lat_cnt;
    logic           hit, grant, grant_en;
    logic [OPW-1:0] win_op;

    // Two passes give the wrap-around search: rr_ptr..NREQ-1 first, then 0..rr_ptr-1.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && IDW'(i) >= rr_ptr && req_valid[i]) begin
                hit = 1'b1;
                win = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && req_valid[i]) begin
                hit = 1'b1;
                win = IDW'(i);
            end
        end
        grant_en  = (state == IDLE) || (state == HOLD && rsp_ready);
        grant     = grant_en && hit;
        req_ready = grant ? (NREQ'(1) << win) : '0;
        rr_nxt    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        win_op = '0;
        for (int i = 0; i < NREQ; i++)
            if (IDW'(i) == win) win_op = req_op[i*OPW +: OPW];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = EXEC;
            EXEC:    if (lat_cnt == '0) state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = grant ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            add_op    <= '0;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_es    <= '0;
            rsp_fs    <= '0;
            rsp_ss    <= 1'b0;
            rsp_fls   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                add_op  <= win_op;
                id_q    <= win;
                rr_ptr  <= rr_nxt;
                lat_cnt <= 3'(ADD_LAT - 1);
            end else if (state == EXEC && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            // Adder outputs are only trusted on the final latency edge.
            if (state == EXEC && lat_cnt == '0) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                rsp_es    <= add_es;
                rsp_fs    <= add_fs;
                rsp_ss    <= add_ss;
                rsp_fls   <= add_fls;
            end else if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef FP_ADD_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done     <= '0;
            stall_cycles <= '0;
        end else begin
            if (rsp_valid && rsp_ready) ops_done <= ops_done + 32'd1;
            if (rsp_valid && !rsp_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched (NREQ=3, ADD_LAT=3): directed table, async reset cases,
// then random traffic against a transaction-level model.
module tb_fp_add_sched;
    localparam int N   = 3;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       rv = '0;
    logic [N-1:0]       req_ready;
    logic [N*141-1:0]   req_op = '0;
    logic [140:0]       add_op;
    logic [10:0]        a_es = '0;
    logic [56:0]        a_fs = '0;
    logic               a_ss = 1'b0;
    logic [1:0]         a_fls = '0;
    logic               rsp_valid;
    logic               rdy = 1'b0;
    logic [IDW-1:0]     rsp_id;
    logic [10:0]        rsp_es;
    logic [56:0]        rsp_fs;
    logic               rsp_ss;
    logic [1:0]         rsp_fls;
    logic               busy;
`ifdef FP_ADD_SCHED_STATS_EN
    logic [31:0]        ops_done, stall_cycles;
`endif

    fp_add_sched #(.NREQ(N), .ADD_LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv), .req_ready(req_ready), .req_op(req_op),
        .add_op(add_op), .add_es(a_es), .add_fs(a_fs), .add_ss(a_ss), .add_fls(a_fls),
        .rsp_valid(rsp_valid), .rsp_ready(rdy), .rsp_id(rsp_id),
        .rsp_es(rsp_es), .rsp_fs(rsp_fs), .rsp_ss(rsp_ss), .rsp_fls(rsp_fls),
        .busy(busy)
`ifdef FP_ADD_SCHED_STATS_EN
        , .ops_done(ops_done), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: an op in flight counts edges since its grant.
    int           m_rr, m_cnt, m_wid;
    bit           m_pend, m_hold;
    logic [140:0] m_op;
    logic [IDW-1:0] m_id;
    logic [10:0]  m_es;
    logic [56:0]  m_fs;
    logic         m_ss;
    logic [1:0]   m_fls;
    logic [31:0]  m_ops, m_stall;

    typedef struct {
        logic [N-1:0]   rv;
        logic           rdy;
        logic [N-1:0]   exp_ready;
        logic           exp_valid;
        logic           exp_busy;
        logic [IDW-1:0] exp_id;
    } vec_t;

    task automatic chk(input string nm, input logic [140:0] act, input logic [140:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_cnt = 0; m_wid = 0; m_pend = 0; m_hold = 0;
        m_op = '0; m_id = '0; m_es = '0; m_fs = '0; m_ss = 1'b0; m_fls = '0;
        m_ops = '0; m_stall = '0;
    endtask

    function automatic logic [N-1:0] exp_grant();
        if (m_pend || (m_hold && !rdy)) return '0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (rv[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic rand_data();
        for (int b = 0; b < N*141; b++) req_op[b] = 1'($urandom);
        a_es  = 11'($urandom);
        a_fs  = 57'({$urandom, $urandom});
        a_ss  = 1'($urandom);
        a_fls = 2'($urandom);
    endtask

    // Called just after the negedge with inputs applied: compare, cross the edge, update the model.
    task automatic step_model();
        logic [N-1:0] g;
        g = exp_grant();
        chk("req_ready", 141'(req_ready), 141'(g));
        chk("busy", 141'(busy), 141'(m_pend || m_hold));
        chk("rsp_valid", 141'(rsp_valid), 141'(m_hold));
        chk("add_op", add_op, m_op);
        chk("rsp_id", 141'(rsp_id), 141'(m_id));
        chk("rsp_es", 141'(rsp_es), 141'(m_es));
        chk("rsp_fs", 141'(rsp_fs), 141'(m_fs));
        chk("rsp_ss_fls", 141'({rsp_ss, rsp_fls}), 141'({m_ss, m_fls}));
`ifdef FP_ADD_SCHED_STATS_EN
        chk("ops_done", 141'(ops_done), 141'(m_ops));
        chk("stall_cycles", 141'(stall_cycles), 141'(m_stall));
`endif
        @(posedge clk);
        if (m_hold && !rdy && m_stall != '1) m_stall++;
        if (m_hold && rdy) begin
            m_hold = 0;
            m_ops++;
        end
        if (m_pend) begin
            m_cnt++;
            if (m_cnt == LAT) begin
                m_pend = 0; m_hold = 1;
                m_id = IDW'(m_wid);
                m_es = a_es; m_fs = a_fs; m_ss = a_ss; m_fls = a_fls;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                m_pend = 1; m_cnt = 0; m_wid = i;
                m_op = req_op[i*141 +: 141];
                m_rr = (i + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 141'(busy), '0);
        chk({nm, "_rsp_valid"}, 141'(rsp_valid), '0);
        chk({nm, "_add_op"}, add_op, '0);
        chk({nm, "_req_ready"}, 141'(req_ready), '0);
        chk({nm, "_rsp"}, 141'({rsp_id, rsp_es, rsp_fs, rsp_ss, rsp_fls}), '0);
    endtask

    task automatic async_reset(input string nm);
        rv = '0;
        #2 rst_n = 1'b0;
        #1 check_zero(nm);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tab[13];

    initial begin
        // Rows are cycles from reset release: grant 0, result after 3 edges, accept,
        // wrap-around grant of requester 2, 2 stall cycles, back-to-back issue to requester 0.
        tab[0]  = '{3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0};
        tab[1]  = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0};
        tab[2]  = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0};
        tab[3]  = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0};
        tab[4]  = '{3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0};
        tab[5]  = '{3'b101, 1'b1, 3'b100, 1'b0, 1'b0, 2'd0};
        tab[6]  = '{3'b101, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0};
        tab[7]  = '{3'b101, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0};
        tab[8]  = '{3'b101, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0};
        tab[9]  = '{3'b101, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2};
        tab[10] = '{3'b101, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2};
        tab[11] = '{3'b101, 1'b1, 3'b001, 1'b1, 1'b1, 2'd2};
        tab[12] = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2};

        model_reset();
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tab[r]) begin
            rv  = tab[r].rv;
            rdy = tab[r].rdy;
            rand_data();
            #1;
            chk($sformatf("tab%0d_ready", r), 141'(req_ready), 141'(tab[r].exp_ready));
            chk($sformatf("tab%0d_valid", r), 141'(rsp_valid), 141'(tab[r].exp_valid));
            chk($sformatf("tab%0d_busy", r), 141'(busy), 141'(tab[r].exp_busy));
            chk($sformatf("tab%0d_id", r), 141'(rsp_id), 141'(tab[r].exp_id));
            step_model();
        end

        // Reset while in EXEC (requester 0 issued by the last table rows).
        async_reset("rst_exec");

        // Requester 1 issues, reaches HOLD with rsp_ready low, then reset hits.
        rv = 3'b010; rdy = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            rand_data();
            #1 step_model();
            rv = '0;
        end
        chk("hold_before_rst", 141'(rsp_valid), 141'(1));
        async_reset("rst_hold");
        rv = 3'b111; rdy = 1'b1;
        rand_data();
        #1 chk("post_rst_first", 141'(req_ready), 141'(3'b001));
        step_model();

        // Randomized traffic with changing adder outputs every cycle.
        for (int c = 0; c < 800; c++) begin
            rv  = N'($urandom);
            rdy = ($urandom % 4) != 0;
            rand_data();
            #1 step_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
